// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, then a sign fix-up cycle.
// Latency: start edge k -> div_done during the cycle after edge k+WIDTH+1; optional DIV_ZERO_FAST_EN finishes divide-by-zero in 1.
// Backpressure: div_busy stalls the pipe; div_start while busy is ignored; div_flush abandons the operation in flight.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_flush,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] div_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisorAbs;
    logic [CW-1:0]    count;
    logic             quotNeg;
    logic             remNeg;
    logic             byZero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fastZero;

`ifdef DIV_ZERO_FAST_EN
    assign fastZero = (divisor == '0);
`else
    assign fastZero = 1'b0;
`endif

    // Partial remainder is always below the divisor, so WIDTH bits hold it; the trial needs WIDTH+1.
    assign shifted  = {rem, quot[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisorAbs};
    assign div_busy = (state != IDLE);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (div_start && !fastZero) nextState = RUN;
            RUN:     if (count == CW'(1)) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (div_flush) nextState = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rem         <= '0;
            quot        <= '0;
            divisorAbs  <= '0;
            count       <= '0;
            quotNeg     <= 1'b0;
            remNeg      <= 1'b0;
            byZero      <= 1'b0;
            div_done    <= 1'b0;
            div_lo      <= '0;
            div_hi      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state    <= nextState;
            div_done <= 1'b0;
            if (!div_flush) begin
                case (state)
                    IDLE: begin
                        if (div_start) begin
                            if (fastZero) begin
                                div_lo      <= '1;
                                div_hi      <= dividend;
                                div_by_zero <= 1'b1;
                                div_done    <= 1'b1;
                            end else begin
                                rem        <= '0;
                                quot       <= (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                                divisorAbs <= (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                                quotNeg    <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                                remNeg     <= div_signed && dividend[WIDTH-1];
                                byZero     <= (divisor == '0);
                                count      <= CW'(WIDTH);
                            end
                        end
                    end
                    RUN: begin
                        if (!trial[WIDTH]) begin
                            rem  <= trial[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= shifted[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b0};
                        end
                        count <= count - 1'b1;
                    end
                    FIX: begin
                        // On divide-by-zero rem holds |dividend|, so the remainder negate restores the raw dividend.
                        div_lo      <= byZero ? '1 : (quotNeg ? -quot : quot);
                        div_hi      <= remNeg ? -rem : rem;
                        div_by_zero <= byZero;
                        div_done    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
